// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_counter
// Description : Time-of-day counter; prescales clk to a one-second tick and
//               advances a cascaded hour:minute:second count with set mode.
// Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
    parameter int CLK_DIV = 4,
    parameter int HOUR    = 5,
    parameter int MINUTE  = 3,
    parameter int SECOND  = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_mode,
    input  logic [2:0] signal_increase,
    input  logic [2:0] signal_decrease,
    output logic [7:0] cur_second,
    output logic [7:0] cur_minute,
    output logic [7:0] cur_hour,
    output logic       sec_tick,
    output logic       day_wrap
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
    localparam logic [7:0]       c_SEC_MAX  = 8'(SECOND - 1);
    localparam logic [7:0]       c_MIN_MAX  = 8'(MINUTE - 1);
    localparam logic [7:0]       c_HOUR_MAX = 8'(HOUR - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_enable;
    logic             w_tick;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic             w_hour_wrap;
    logic             w_day_wrap;
    logic [7:0]       w_sec_nxt;
    logic [7:0]       w_min_nxt;
    logic [7:0]       w_hour_nxt;

    function automatic logic [7:0] f_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] f_dec(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0) ? max : v - 8'd1;
    endfunction

    assign w_enable    = run & ~set_mode;
    assign w_tick      = w_enable && (r_div_cnt == c_DIV_MAX);
    assign w_sec_wrap  = (cur_second == c_SEC_MAX);
    assign w_min_wrap  = (cur_minute == c_MIN_MAX);
    assign w_hour_wrap = (cur_hour == c_HOUR_MAX);
    assign w_day_wrap  = w_tick & w_sec_wrap & w_min_wrap & w_hour_wrap;

    // Set-mode adjustments are per-field with no carry; increase beats decrease.
    always_comb begin
        w_sec_nxt  = cur_second;
        w_min_nxt  = cur_minute;
        w_hour_nxt = cur_hour;
        if (set_mode) begin
            if (|signal_increase) begin
                if (signal_increase[0]) w_sec_nxt  = f_inc(cur_second, c_SEC_MAX);
                if (signal_increase[1]) w_min_nxt  = f_inc(cur_minute, c_MIN_MAX);
                if (signal_increase[2]) w_hour_nxt = f_inc(cur_hour,   c_HOUR_MAX);
            end else begin
                if (signal_decrease[0]) w_sec_nxt  = f_dec(cur_second, c_SEC_MAX);
                if (signal_decrease[1]) w_min_nxt  = f_dec(cur_minute, c_MIN_MAX);
                if (signal_decrease[2]) w_hour_nxt = f_dec(cur_hour,   c_HOUR_MAX);
            end
        end else if (w_tick) begin
            w_sec_nxt = f_inc(cur_second, c_SEC_MAX);
            if (w_sec_wrap) begin
                w_min_nxt = f_inc(cur_minute, c_MIN_MAX);
                if (w_min_wrap) begin
                    w_hour_nxt = f_inc(cur_hour, c_HOUR_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            cur_second <= 8'd0;
            cur_minute <= 8'd0;
            cur_hour   <= 8'd0;
            sec_tick   <= 1'b0;
            day_wrap   <= 1'b0;
        end else begin
            // Set mode parks the prescaler so the first tick after exit is a full period away.
            if (set_mode) begin
                r_div_cnt <= '0;
            end else if (run) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DIV_ONE;
            end
            cur_second <= w_sec_nxt;
            cur_minute <= w_min_nxt;
            cur_hour   <= w_hour_nxt;
            sec_tick   <= w_tick;
            day_wrap   <= w_day_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_counter
// Description : Scoreboard bench for time_counter with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       set_mode;
    logic [2:0] signal_increase;
    logic [2:0] signal_decrease;
    logic [7:0] cur_second;
    logic [7:0] cur_minute;
    logic [7:0] cur_hour;
    logic       sec_tick;
    logic       day_wrap;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  h;
        logic [7:0]  m;
        logic [7:0]  s;
        logic        tick;
        logic        wrap;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    cyc     = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    time_counter #(
        .CLK_DIV (4),
        .HOUR    (5),
        .MINUTE  (3),
        .SECOND  (21)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .set_mode        (set_mode),
        .signal_increase (signal_increase),
        .signal_decrease (signal_decrease),
        .cur_second      (cur_second),
        .cur_minute      (cur_minute),
        .cur_hour        (cur_hour),
        .sec_tick        (sec_tick),
        .day_wrap        (day_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compare the outputs sampled on the falling edge against queued expectations.
    always @(negedge clk) begin
        while (q_exp.size() > 0 && q_exp[0].cyc <= 32'(cyc)) begin
            exp_t  e;
            string nm;
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_tests = n_tests + 1;
            if (cur_hour !== e.h || cur_minute !== e.m || cur_second !== e.s ||
                sec_tick !== e.tick || day_wrap !== e.wrap) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %0d:%0d:%0d tick=%b wrap=%b, expected %0d:%0d:%0d tick=%b wrap=%b",
                         nm, cur_hour, cur_minute, cur_second, sec_tick, day_wrap,
                         e.h, e.m, e.s, e.tick, e.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input int h, input int m, input int s,
                              input bit tick, input bit wrap);
        exp_t e;
        e.cyc  = 32'(cyc);
        e.h    = 8'(h);
        e.m    = 8'(m);
        e.s    = 8'(s);
        e.tick = tick;
        e.wrap = wrap;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    initial begin
        rst_n           = 1'b0;
        run             = 1'b0;
        set_mode        = 1'b0;
        signal_increase = 3'b000;
        signal_decrease = 3'b000;
        step(2);
        expect_now("reset", 0, 0, 0, 0, 0);

        // Basic tick
        rst_n = 1'b1;
        run   = 1'b1;
        step(3);  expect_now("pre_tick1", 0, 0, 0, 0, 0);
        step(1);  expect_now("tick1", 0, 0, 1, 1, 0);
        step(3);  expect_now("between_ticks", 0, 0, 1, 0, 0);
        step(1);  expect_now("tick2", 0, 0, 2, 1, 0);

        // Full cascade (2 ticks so far)
        step(19 * 4);  expect_now("cascade_21", 0, 1, 0, 1, 0);
        step(42 * 4);  expect_now("cascade_63", 1, 0, 0, 1, 0);
        step(251 * 4); expect_now("cascade_314", 4, 2, 20, 1, 0);
        step(4);       expect_now("day_wrap", 0, 0, 0, 1, 1);
        step(1);       expect_now("day_wrap_one_cycle", 0, 0, 0, 0, 0);

        // Set mode adjustments
        set_mode        = 1'b1;
        signal_decrease = 3'b111;
        step(1);  expect_now("dec_all_underflow", 4, 2, 20, 0, 0);
        signal_increase = 3'b001;
        signal_decrease = 3'b010;
        step(1);  expect_now("inc_beats_dec", 4, 2, 0, 0, 0);
        signal_increase = 3'b000;
        signal_decrease = 3'b000;
        step(1);  expect_now("set_idle_frozen", 4, 2, 0, 0, 0);
        signal_increase = 3'b111;
        step(1);  expect_now("inc_all_no_carry", 0, 0, 1, 0, 0);
        signal_increase = 3'b000;
        signal_decrease = 3'b001;
        step(1);  expect_now("dec_second", 0, 0, 0, 0, 0);
        signal_decrease = 3'b000;
        signal_increase = 3'b010;
        step(2);  expect_now("hold_inc_two", 0, 2, 0, 0, 0);
        signal_increase = 3'b000;

        // Set-mode exit: first tick four enabled cycles after the drop
        set_mode = 1'b0;
        step(3);  expect_now("exit_no_tick", 0, 2, 0, 0, 0);
        step(1);  expect_now("exit_tick", 0, 2, 1, 1, 0);

        // Pause and ignored adjust pulses
        step(2);
        run = 1'b0;
        step(10); expect_now("pause_hold", 0, 2, 1, 0, 0);
        signal_increase = 3'b111;
        step(1);
        signal_increase = 3'b000;
        signal_decrease = 3'b111;
        step(1);  expect_now("adjust_ignored", 0, 2, 1, 0, 0);
        signal_decrease = 3'b000;
        run = 1'b1;
        step(1);  expect_now("resume_partial", 0, 2, 1, 0, 0);
        step(1);  expect_now("resume_tick", 0, 2, 2, 1, 0);

        // Set mode raised mid-second discards the partial second
        step(2);
        set_mode = 1'b1;
        step(3);  expect_now("mid_set_frozen", 0, 2, 2, 0, 0);
        set_mode = 1'b0;
        step(3);  expect_now("mid_exit_no_tick", 0, 2, 2, 0, 0);
        step(1);  expect_now("mid_exit_tick", 0, 2, 3, 1, 0);

        // Reset mid-count
        step(3);
        rst_n = 1'b0;
        step(2);  expect_now("reset_mid", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(3);  expect_now("post_reset_no_tick", 0, 0, 0, 0, 0);
        step(1);  expect_now("post_reset_tick", 0, 0, 1, 1, 0);

        step(2);
        if (q_exp.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d expectations unchecked, required 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
